// File: rtl/sequenciador_regras.sv
// Rule-inference sequencer for the fuzzy processor.
// Latches the membership degrees of inputs A and B, then walks the 3x3 rule
// base one rule per clock: strength = min(a_i, b_j), aggregated by max into
// one of three consequents. Final aggregates are held on saida_0..2.
module sequenciador_regras #(
    parameter int W        = 8,
    parameter int N_REGRAS = 9
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [3*W-1:0] grau_a,
    input  logic [3*W-1:0] grau_b,
    output logic           busy,
    output logic           done,
    output logic [3:0]     regra,
    output logic [W-1:0]   saida_0,
    output logic [W-1:0]   saida_1,
    output logic [W-1:0]   saida_2
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [3:0] LAST_REGRA = 4'(N_REGRAS - 1);

    state_t       r_state;
    state_t       w_state_next;
    logic [3:0]   r_regra;
    logic [W-1:0] r_a     [3];
    logic [W-1:0] r_b     [3];
    logic [W-1:0] r_acc   [3];
    logic [W-1:0] r_saida [3];

    logic [1:0]   w_i;
    logic [1:0]   w_j;
    logic [2:0]   w_soma;
    logic [1:0]   w_cons;
    logic [W-1:0] w_a_sel;
    logic [W-1:0] w_b_sel;
    logic [W-1:0] w_f;
    logic [W-1:0] w_acc_next [3];
    logic         w_last;

    assign w_last  = (r_regra == LAST_REGRA);
    assign regra   = r_regra;
    assign saida_0 = r_saida[0];
    assign saida_1 = r_saida[1];
    assign saida_2 = r_saida[2];

    // Decode rule index k into A index i = k/3 and B index j = k%3.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        w_i = 2'd0;
        w_j = 2'd0;
        case (r_regra)
            4'd1: begin w_i = 2'd0; w_j = 2'd1; end
            4'd2: begin w_i = 2'd0; w_j = 2'd2; end
            4'd3: begin w_i = 2'd1; w_j = 2'd0; end
            4'd4: begin w_i = 2'd1; w_j = 2'd1; end
            4'd5: begin w_i = 2'd1; w_j = 2'd2; end
            4'd6: begin w_i = 2'd2; w_j = 2'd0; end
            4'd7: begin w_i = 2'd2; w_j = 2'd1; end
            4'd8: begin w_i = 2'd2; w_j = 2'd2; end
            default: ;
        endcase
    end

    // Select the two degrees, take their min and map i+j onto a consequent.
    always_comb begin
        w_a_sel = r_a[0];
        w_b_sel = r_b[0];
        case (w_i)
            2'd1:    w_a_sel = r_a[1];
            2'd2:    w_a_sel = r_a[2];
            default: w_a_sel = r_a[0];
        endcase
        case (w_j)
            2'd1:    w_b_sel = r_b[1];
            2'd2:    w_b_sel = r_b[2];
            default: w_b_sel = r_b[0];
        endcase
        w_f    = (w_a_sel < w_b_sel) ? w_a_sel : w_b_sel;
        w_soma = {1'b0, w_i} + {1'b0, w_j};
        if (w_soma <= 3'd1) begin
            w_cons = 2'd0;
        end else if (w_soma == 3'd2) begin
            w_cons = 2'd1;
        end else begin
            w_cons = 2'd2;
        end
    end

    // Max-aggregate the strength into the selected consequent; others hold.
    always_comb begin
        for (int c = 0; c < 3; c++) begin
            w_acc_next[c] = r_acc[c];
            if ((w_cons == 2'(c)) && (w_f > r_acc[c])) begin
                w_acc_next[c] = w_f;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and status outputs.
    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = ST_EVAL;
                end
            end
            ST_EVAL: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                busy         = 1'b1;
                done         = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Datapath: latch degrees on start, step rules, publish on the last rule.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_regra <= 4'd0;
            // NOTE: the small degree/accumulator arrays are reset too, so an aborted run leaves nothing behind.
            for (int c = 0; c < 3; c++) begin
                r_a[c]     <= '0;
                r_b[c]     <= '0;
                r_acc[c]   <= '0;
                r_saida[c] <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_regra <= 4'd0;
                        for (int c = 0; c < 3; c++) begin
                            r_a[c]   <= grau_a[c*W +: W];
                            r_b[c]   <= grau_b[c*W +: W];
                            r_acc[c] <= '0;
                        end
                    end
                end
                ST_EVAL: begin
                    for (int c = 0; c < 3; c++) begin
                        r_acc[c] <= w_acc_next[c];
                    end
                    if (w_last) begin
                        r_regra <= 4'd0;
                        for (int c = 0; c < 3; c++) begin
                            r_saida[c] <= w_acc_next[c];
                        end
                    end else begin
                        r_regra <= r_regra + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
